// File: rtl/dfp_mul_sched_pkg.sv
// DFPPkg: shared types and constants for the DFP multiplier scheduler.
//   DFP128    - packed 128-bit decimal floating-point operand.
//   DFP128UD  - unpacked decimal result: class flags, sign, exponent and a
//               34-digit BCD significand.
//   state_e   - scheduler FSM states.
//   DFP128UD_QNAN - canonical quiet NaN that the watchdog reports.
package DFPPkg;

    localparam int unsigned DFP128_W     = 128;
    localparam int unsigned DFP_EXP_W    = 14;
    localparam int unsigned DFP_SIG_W    = 136;

    typedef logic [DFP128_W-1:0] DFP128;

    typedef struct packed {
        logic                 nan;
        logic                 qnan;
        logic                 snan;
        logic                 inf;
        logic                 sign;
        logic [DFP_EXP_W-1:0] exp;
        logic [DFP_SIG_W-1:0] sig;
    } DFP128UD;

    localparam int unsigned DFP128UD_W = $bits(DFP128UD);

    localparam DFP128UD DFP128UD_QNAN = '{
        nan:  1'b1,
        qnan: 1'b1,
        snan: 1'b0,
        inf:  1'b0,
        sign: 1'b0,
        exp:  '1,
        sig:  '0
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/dfp_mul_sched_rr.sv
// dfp_rr_arb: combinational round-robin picker.
//   req_i - request vector
//   ptr_i - index of the last winner; the search starts at ptr_i+1 and wraps
//   gnt_o - one-hot winner (all zero when no request)
//   idx_o - binary index of the winner
//   any_o - at least one request present
module dfp_rr_arb #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int unsigned IW = $clog2(NREQ);

    always_comb begin
        int unsigned    c;
        logic [IW-1:0]  ci;
        logic           found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        ci    = '0;
        // Offsets 1..NREQ visit every requester once, ending on the last winner.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            c  = (32'(ptr_i) + k) % NREQ;
            ci = IW'(c);
            if (!found && req_i[ci]) begin
                found     = 1'b1;
                gnt_o[ci] = 1'b1;
                idx_o     = ci;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/dfp_mul_sched.sv
// dfp_mul_sched: shares one DFP128 multiplier among NREQ requesters.
// Round-robin grant, one operation outstanding, result held until the
// consumer handshakes.
//   clk, rst        - clock, synchronous active-high reset
//   req/req_a/req_b - per-requester request and operands (flattened)
//   gnt             - one-hot accept pulse (combinational, in IDLE)
//   mul_*           - multiplier control/data: ce, ld pulse, operands,
//                     result and completion level
//   o/o_valid/o_tag/o_ready - result channel with requester index
//   busy, timeout   - status
// Optional feature: define DFPMS_TIMEOUT_EN to enable the WAIT watchdog
// (TMO cycles); without it, timeout is tied low and WAIT never expires.
module dfp_mul_sched
    import DFPPkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MIN_WAIT = 4,
    parameter int unsigned TMO      = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DFP128_W-1:0] req_a,
    input  logic [NREQ*DFP128_W-1:0] req_b,
    output logic [NREQ-1:0]          gnt,
    output logic                     mul_ce,
    output logic                     mul_ld,
    output logic [DFP128_W-1:0]      mul_a,
    output logic [DFP128_W-1:0]      mul_b,
    input  logic [DFP128UD_W-1:0]    mul_o,
    input  logic                     mul_done,
    output logic [DFP128UD_W-1:0]    o,
    output logic                     o_valid,
    output logic [$clog2(NREQ)-1:0]  o_tag,
    input  logic                     o_ready,
    output logic                     busy,
    output logic                     timeout
);

    localparam int unsigned IW   = $clog2(NREQ);
    localparam int unsigned CMAX = (TMO > MIN_WAIT) ? TMO : MIN_WAIT;
    localparam int unsigned CW   = $clog2(CMAX + 1) + 1;

    state_e                 state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    DFP128                  a_q, a_d;
    DFP128                  b_q, b_d;
    logic [IW-1:0]          tag_q, tag_d;
    logic [DFP128UD_W-1:0]  res_q, res_d;
    logic                   vld_q, vld_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    DFP128                  opa [NREQ];
    DFP128                  opb [NREQ];
    logic [NREQ-1:0]        arb_gnt;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic                   done_ok;
    logic                   wd_hit;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            opa[i] = req_a[i*DFP128_W +: DFP128_W];
            opb[i] = req_b[i*DFP128_W +: DFP128_W];
        end
    end

    dfp_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Early done levels may be left over from a previous operation.
    assign done_ok = mul_done && (cnt_q >= CW'(MIN_WAIT));

`ifdef DFPMS_TIMEOUT_EN
    logic tmo_q, tmo_d;

    // cnt_q == TMO-1 marks the TMO-th WAIT cycle.
    assign wd_hit  = !done_ok && (cnt_q == CW'(TMO - 1));
    assign tmo_d   = tmo_q | ((state_q == WAIT) && wd_hit);
    assign timeout = tmo_q;

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= 1'b0;
        else     tmo_q <= tmo_d;
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        res_d   = res_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        mul_ld  = 1'b0;
        mul_ce  = 1'b0;
        busy    = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt     = arb_gnt;
                    ptr_d   = arb_idx;
                    tag_d   = arb_idx;
                    a_d     = opa[arb_idx];
                    b_d     = opb[arb_idx];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mul_ld  = 1'b1;
                mul_ce  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                mul_ce = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (done_ok) begin
                    res_d   = mul_o;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else if (wd_hit) begin
                    res_d   = DFP128UD_QNAN;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (o_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset wins over a same-cycle request: no requester may see an
        // accept that the registers are about to discard.
        if (rst) begin
            gnt    = '0;
            mul_ld = 1'b0;
            mul_ce = 1'b0;
            busy   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mul_a   = a_q;
    assign mul_b   = b_q;
    assign o       = res_q;
    assign o_valid = vld_q;
    assign o_tag   = tag_q;

endmodule

// File: tb/tb_dfp_mul_sched.sv
// Self-checking bench for dfp_mul_sched (NREQ=4, MIN_WAIT=4, TMO=16).
// A behavioural multiplier answers with a fixed function of the operands;
// expected results are queued at grant and compared when o_valid rises.
module tb_dfp_mul_sched;
    import DFPPkg::*;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned MIN_WAIT = 4;
    localparam int unsigned TMO_P    = 16;
    localparam int unsigned IW       = $clog2(NREQ);
    localparam int unsigned RW       = DFP128UD_W;
    localparam int unsigned AW       = DFP128_W;
`ifdef DFPMS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_a, req_b;
    logic [NREQ-1:0]     gnt;
    logic                mul_ce, mul_ld, mul_done;
    logic [AW-1:0]       mul_a, mul_b;
    logic [RW-1:0]       mul_o, o;
    logic                o_valid, o_ready, busy, timeout;
    logic [IW-1:0]       o_tag;

    DFP128 opa [NREQ];
    DFP128 opb [NREQ];

    typedef struct packed {
        logic [IW-1:0] tag;
        logic [RW-1:0] res;
    } exp_t;
    exp_t sb [$];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_a[i*AW +: AW] = opa[i];
            req_b[i*AW +: AW] = opb[i];
        end
    end

    function automatic logic [RW-1:0] mk_res(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return {b[RW-AW-1:0], a ^ {b[63:0], b[127:64]}};
    endfunction

    function automatic logic [RW-1:0] qnan();
        DFP128UD q;
        q      = '0;
        q.nan  = 1'b1;
        q.qnan = 1'b1;
        q.exp  = '1;
        return q;
    endfunction

    function automatic DFP128 rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    assign mul_o = mk_res(mul_a, mul_b);

    dfp_mul_sched #(
        .NREQ     (NREQ),
        .MIN_WAIT (MIN_WAIT),
        .TMO      (TMO_P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_a    (req_a),
        .req_b    (req_b),
        .gnt      (gnt),
        .mul_ce   (mul_ce),
        .mul_ld   (mul_ld),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_o    (mul_o),
        .mul_done (mul_done),
        .o        (o),
        .o_valid  (o_valid),
        .o_tag    (o_tag),
        .o_ready  (o_ready),
        .busy     (busy),
        .timeout  (timeout)
    );

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the edge, outputs sampled 1 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        o_ready  = 1'b0;
        mul_done = 1'b0;
        #1;
        chk("rst_gnt", gnt, '0);
        next_cycle();
        #1;
        chk("rst_gnt2",    gnt,     '0);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_ovalid",  o_valid, 1'b0);
        chk("rst_o",       o,       '0);
        chk("rst_otag",    o_tag,   '0);
        chk("rst_mula",    mul_a,   '0);
        chk("rst_mulb",    mul_b,   '0);
        chk("rst_ld",      mul_ld,  1'b0);
        chk("rst_ce",      mul_ce,  1'b0);
        chk("rst_timeout", timeout, 1'b0);
        next_cycle();
        rst = 1'b0;
    endtask

    // One full transaction starting in an IDLE cycle whose req is already driven.
    task automatic run_txn(input int unsigned widx, input int unsigned done_k,
                           input int unsigned stale, input bit held,
                           input int unsigned ready_wait, input bit drop, input bit tmo);
        exp_t        e, pe;
        DFP128       ea, eb;
        int unsigned acc;
        acc      = tmo ? TMO_P : (held ? MIN_WAIT + 1 : done_k);
        mul_done = held;
        #1;
        chk("gnt",       gnt,  NREQ'(1) << widx);
        chk("idle_busy", busy, 1'b0);
        ea    = opa[IW'(widx)];
        eb    = opb[IW'(widx)];
        e.tag = IW'(widx);
        e.res = tmo ? qnan() : mk_res(ea, eb);
        sb.push_back(e);

        next_cycle();
        if (drop) req[IW'(widx)] = 1'b0;
        else begin
            opa[IW'(widx)] = rnd128();
            opb[IW'(widx)] = rnd128();
        end
        #1;
        chk("load_ld",   mul_ld, 1'b1);
        chk("load_ce",   mul_ce, 1'b1);
        chk("load_mula", mul_a,  ea);
        chk("load_mulb", mul_b,  eb);
        chk("load_gnt",  gnt,    '0);

        for (int unsigned k = 1; k <= acc; k++) begin
            next_cycle();
            mul_done = held || (k == done_k) || (k == stale);
            #1;
            chk("wait_ovalid", o_valid, 1'b0);
            chk("wait_ce",     mul_ce,  1'b1);
            chk("wait_ld",     mul_ld,  1'b0);
        end

        next_cycle();
        mul_done = 1'b0;
        o_ready  = (ready_wait == 0);
        #1;
        chk("resp_valid", o_valid, 1'b1);
        chk("sb_size",    RW'(sb.size()), RW'(1));
        if (sb.size() != 0) begin
            pe = sb.pop_front();
            chk("resp_o",    o,     pe.res);
            chk("resp_otag", o_tag, pe.tag);
        end
        chk("resp_ce",      mul_ce,  1'b0);
        chk("resp_busy",    busy,    1'b1);
        chk("resp_timeout", timeout, tmo);
        chk("resp_mula",    mul_a,   ea);

        for (int unsigned r = 1; r <= ready_wait; r++) begin
            next_cycle();
            o_ready = (r == ready_wait);
            #1;
            chk("hold_valid", o_valid, 1'b1);
            chk("hold_o",     o,       e.res);
            chk("hold_otag",  o_tag,   e.tag);
            chk("hold_ce",    mul_ce,  1'b0);
            chk("hold_gnt",   gnt,     '0);
        end

        next_cycle();
        o_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst      = 1'b1;
        req      = 4'b1111;
        o_ready  = 1'b0;
        mul_done = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            opa[i] = rnd128();
            opb[i] = rnd128();
        end

        // Reset with every requester active; then an idle cycle.
        do_reset();
        req = '0;
        #1;
        chk("idle_gnt",  gnt,    '0);
        chk("idle_busy", busy,   1'b0);
        chk("idle_ce",   mul_ce, 1'b0);
        next_cycle();

        // Single request, done 6 cycles after mul_ld.
        req = 4'b0001;
        run_txn(0, 6, 0, 1'b0, 0, 1'b1, 1'b0);

        // All requesting from reset: rotation 0,1,2,3,0 (one stale early done).
        do_reset();
        req = 4'b1111;
        run_txn(0, 5, 0, 1'b0, 0, 1'b0, 1'b0);
        run_txn(1, 7, 0, 1'b0, 0, 1'b0, 1'b0);
        run_txn(2, 6, 2, 1'b0, 0, 1'b0, 1'b0);
        run_txn(3, 9, 0, 1'b0, 0, 1'b0, 1'b0);
        run_txn(0, 5, 0, 1'b0, 0, 1'b0, 1'b0);

        // Done held from before LOAD; consumer stalls 10 cycles.
        run_txn(1, 0, 0, 1'b1, 10, 1'b0, 1'b0);

        // Requesters 1..3 withdraw before any grant; pointer at 1 -> 0 wins.
        req = 4'b0001;
        run_txn(0, 6, 0, 1'b0, 0, 1'b1, 1'b0);

        // Reset in WAIT, late done afterwards.
        req = 4'b0100;
        #1;
        chk("rw_gnt", gnt, 4'b0100);
        next_cycle();
        req = '0;
        #1;
        chk("rw_ld", mul_ld, 1'b1);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rw_rst_gnt", gnt, '0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rw_busy",   busy,    1'b0);
        chk("rw_ovalid", o_valid, 1'b0);
        next_cycle();
        mul_done = 1'b1;
        #1;
        chk("rw_late_ovalid", o_valid, 1'b0);
        next_cycle();
        mul_done = 1'b0;
        #1;
        chk("rw_after_ovalid", o_valid, 1'b0);
        chk("rw_after_busy",   busy,    1'b0);
        chk("rw_after_ce",     mul_ce,  1'b0);
        chk("rw_after_o",      o,       '0);
        next_cycle();

        // Pointer reset to favour 0: with 1 and 3 requesting, 1 then 3.
        req = 4'b1010;
        run_txn(1, 5, 0, 1'b0, 0, 1'b1, 1'b0);
        run_txn(3, 7, 3, 1'b0, 2, 1'b1, 1'b0);

        // Long wait: watchdog expiry when enabled, otherwise a late done.
        req = 4'b0001;
        if (TMO_EN) run_txn(0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
        else        run_txn(0, 40, 0, 1'b0, 0, 1'b1, 1'b0);
        #1;
        chk("end_busy",    busy,    1'b0);
        chk("end_gnt",     gnt,     '0);
        chk("end_timeout", timeout, TMO_EN);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
